ex_alu_md: RTL and testbench

//  Parametrised execute unit for the MIPS core; successor to the single-cycle 4-op ALU.

---
 rtl/ex_alu_md_pkg.sv | 35 +++
 rtl/ex_alu_md_if.sv | 28 ++
 rtl/ex_muldiv_iter.sv | 75 +++++++
 rtl/ex_alu_md.sv | 125 ++++++++++++
 tb/tb_ex_alu_md.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/ex_alu_md_pkg.sv
// Shared definitions for the execute unit: ALUOp encodings, FSM states and decode helpers.
// Op codes 0-3 match the old 4-op ALU so existing decode stays valid.
package ex_alu_md_pkg;

  typedef enum logic [3:0] {
    ALU_ADDU  = 4'h0,
    ALU_SUBU  = 4'h1,
    ALU_OR    = 4'h2,
    ALU_ADD   = 4'h3,
    ALU_SUB   = 4'h4,
    ALU_AND   = 4'h5,
    ALU_XOR   = 4'h6,
    ALU_NOR   = 4'h7,
    ALU_SLT   = 4'h8,
    ALU_SLTU  = 4'h9,
    ALU_SLL   = 4'hA,
    ALU_SRL   = 4'hB,
    ALU_SRA   = 4'hC,
    ALU_MULTU = 4'hD,
    ALU_DIVU  = 4'hE,
    ALU_MFHI  = 4'hF
  } aluop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_multicycle(aluop_e op);
    return (op == ALU_MULTU) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/ex_alu_md_if.sv
// Valid/ready operand and result bus between the pipeline and the execute unit.
interface ex_alu_md_if #(
  parameter int WIDTH   = 32,
  parameter int ALUOP_W = 4
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [ALUOP_W-1:0] ALUOp;
  logic [WIDTH-1:0]   rdata1;
  logic [WIDTH-1:0]   rdata2;
  logic [WIDTH-1:0]   imm32;
  logic               BSel;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   ALUout;
  logic               ovf;

  modport master (
    output flush, in_valid, ALUOp, rdata1, rdata2, imm32, BSel, out_ready,
    input  in_ready, out_valid, ALUout, ovf
  );

  modport slave (
    input  flush, in_valid, ALUOp, rdata1, rdata2, imm32, BSel, out_ready,
    output in_ready, out_valid, ALUout, ovf
  );
endinterface

// File: rtl/ex_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine, one bit per cycle.
// hi/lo hold the partial product, or the partial remainder/quotient, while busy.
module ex_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    count;
  logic             busy;
  logic             div_mode;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;

  assign done = busy && (count == CW'(WIDTH - 1));

  // A borrow out of trial means the shifted remainder is below the divisor.
  always_comb begin
    hi_n    = hi;
    lo_n    = lo;
    add_sum = {1'b0, hi} + {1'b0, (lo[0] ? b : '0)};
    trial   = {hi, lo[WIDTH-1]} - {1'b0, b};
    if (div_mode) begin
      if (!trial[WIDTH]) begin
        hi_n = trial[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = {hi[WIDTH-2:0], lo[WIDTH-1]};
        lo_n = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      {hi_n, lo_n} = {add_sum, lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      count    <= '0;
      div_mode <= 1'b0;
      b        <= '0;
      hi       <= '0;
      lo       <= '0;
    end else if (flush) begin
      busy  <= 1'b0;
      count <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      count    <= '0;
      div_mode <= is_div;
      hi       <= '0;
      lo       <= is_div ? op1 : op2;
      b        <= is_div ? op2 : op1;
    end else if (busy) begin
      hi    <= hi_n;
      lo    <= lo_n;
      count <= count + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_alu_md.sv
// Execute unit: single-cycle ALU ops plus iterative MULTU/DIVU into HI, with
// valid/ready handshakes on both sides and a registered, held result.
module ex_alu_md
  import ex_alu_md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ALUOP_W = 4
) (
  input logic        clk,
  input logic        rst_n,
  ex_alu_md_if.slave bus
);
  localparam int SW = $clog2(WIDTH);

  state_e             state, state_n;
  aluop_e             opc;
  logic [ALUOP_W-1:0] op_raw;
  logic [WIDTH-1:0]   op1, op2, sum, diff, alu_res;
  logic [WIDTH-1:0]   hi_q, alu_out_q, eng_hi, eng_lo;
  logic [SW-1:0]      shamt;
  logic               alu_ovf, ovf_q, out_valid_q;
  logic               accept, start, eng_done, multi;

  assign op_raw = bus.ALUOp;
  assign opc    = aluop_e'(op_raw);
  assign op1    = bus.rdata1;
  assign op2    = bus.BSel ? bus.imm32 : bus.rdata2;
  assign shamt  = op2[SW-1:0];
  assign sum    = op1 + op2;
  assign diff   = op1 - op2;
  assign multi  = is_multicycle(opc);

  assign bus.in_ready  = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign start         = accept && !bus.flush && multi;
  assign bus.out_valid = out_valid_q;
  assign bus.ALUout    = alu_out_q;
  assign bus.ovf       = ovf_q;

  ex_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (bus.flush),
    .start  (start),
    .is_div (opc == ALU_DIVU),
    .op1    (op1),
    .op2    (op2),
    .done   (eng_done),
    .hi     (eng_hi),
    .lo     (eng_lo)
  );

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (opc)
      ALU_ADDU: alu_res = sum;
      ALU_SUBU: alu_res = diff;
      ALU_OR:   alu_res = op1 | op2;
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]);
      end
      ALU_AND:  alu_res = op1 & op2;
      ALU_XOR:  alu_res = op1 ^ op2;
      ALU_NOR:  alu_res = ~(op1 | op2);
      ALU_SLT:  alu_res = WIDTH'($signed(op1) < $signed(op2));
      ALU_SLTU: alu_res = WIDTH'(op1 < op2);
      ALU_SLL:  alu_res = op1 << shamt;
      ALU_SRL:  alu_res = op1 >> shamt;
      ALU_SRA:  alu_res = $signed(op1) >>> shamt;
      ALU_MFHI: alu_res = hi_q;
      default:  alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (accept && opc == ALU_MULTU)     state_n = ST_MUL;
        else if (accept && opc == ALU_DIVU) state_n = ST_DIV;
      end
      ST_MUL, ST_DIV: if (eng_done) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (bus.flush) state_n = ST_IDLE;
  end

  // LO is only observable through ALUout, so only HI gets an architectural register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      ovf_q       <= 1'b0;
      hi_q        <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= !multi;
      if (!multi) begin
        alu_out_q <= alu_res;
        ovf_q     <= alu_ovf;
      end
    end else if (state == ST_DONE) begin
      hi_q        <= eng_hi;
      alu_out_q   <= eng_lo;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_alu_md.sv
// Directed self-checking bench for ex_alu_md: ALU ops, mul/div latency, stall, flush, reset.
module tb_ex_alu_md;
  import ex_alu_md_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc;
  int   seen;

  ex_alu_md_if #(.WIDTH(32), .ALUOP_W(4)) bus ();

  ex_alu_md #(.WIDTH(32), .ALUOP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // The unselected operand source carries the complement so a wrong BSel shows up.
  task automatic applyStimulus(input aluop_e op, input logic [31:0] a, input logic [31:0] b,
                               input logic bsel);
    @(negedge clk);
    bus.ALUOp    = op;
    bus.rdata1   = a;
    bus.BSel     = bsel;
    bus.rdata2   = bsel ? ~b : b;
    bus.imm32    = bsel ? b : ~b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic waitResult(output int n);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.out_valid) n = -1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.ALUOp = 4'h0;
    bus.rdata1 = '0;
    bus.rdata2 = '0;
    bus.imm32 = '0;
    bus.BSel = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_aluout", bus.ALUout, 32'h0);
    checkOutput("reset_ovf", bus.ovf, 0);
    checkOutput("reset_in_ready", bus.in_ready, 1);

    applyStimulus(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0);
    checkOutput("add_valid", bus.out_valid, 1);
    checkOutput("add_result", bus.ALUout, 32'h8000_0000);
    checkOutput("add_ovf", bus.ovf, 1);

    applyStimulus(ALU_ADDU, 32'h7FFF_FFFF, 32'h1, 1'b0);
    checkOutput("addu_result", bus.ALUout, 32'h8000_0000);
    checkOutput("addu_ovf", bus.ovf, 0);

    applyStimulus(ALU_SUB, 32'h8000_0000, 32'h1, 1'b0);
    checkOutput("sub_result", bus.ALUout, 32'h7FFF_FFFF);
    checkOutput("sub_ovf", bus.ovf, 1);

    applyStimulus(ALU_AND, 32'h0000_00FF, 32'h0000_000F, 1'b1);
    checkOutput("and_imm", bus.ALUout, 32'h0000_000F);

    applyStimulus(ALU_SRA, 32'h8000_0000, 32'h0000_0024, 1'b0);
    checkOutput("sra_masked_shamt", bus.ALUout, 32'hF800_0000);

    applyStimulus(ALU_SRL, 32'h8000_0000, 32'h0000_0004, 1'b0);
    checkOutput("srl", bus.ALUout, 32'h0800_0000);

    applyStimulus(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 1'b0);
    checkOutput("sltu", bus.ALUout, 32'h0);

    applyStimulus(ALU_NOR, 32'h0, 32'h0, 1'b0);
    checkOutput("nor", bus.ALUout, 32'hFFFF_FFFF);

    applyStimulus(ALU_XOR, 32'hA5A5_0F0F, 32'hFFFF_0000, 1'b0);
    checkOutput("xor", bus.ALUout, 32'h5A5A_0F0F);

    applyStimulus(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    checkOutput("multu_in_ready_busy", bus.in_ready, 0);
    waitResult(cyc);
    checkOutput("multu_latency", cyc, 33);
    checkOutput("multu_lo", bus.ALUout, 32'h0000_0001);
    checkOutput("multu_ovf", bus.ovf, 0);
    applyStimulus(ALU_MFHI, 32'h0, 32'h0, 1'b0);
    checkOutput("multu_hi", bus.ALUout, 32'hFFFF_FFFE);

    applyStimulus(ALU_DIVU, 32'd100, 32'd7, 1'b0);
    waitResult(cyc);
    checkOutput("divu_latency", cyc, 33);
    checkOutput("divu_quotient", bus.ALUout, 32'd14);
    applyStimulus(ALU_MFHI, 32'h0, 32'h0, 1'b0);
    checkOutput("divu_remainder", bus.ALUout, 32'd2);

    applyStimulus(ALU_DIVU, 32'd5, 32'd0, 1'b0);
    waitResult(cyc);
    checkOutput("div0_latency", cyc, 33);
    checkOutput("div0_quotient", bus.ALUout, 32'hFFFF_FFFF);
    applyStimulus(ALU_MFHI, 32'h0, 32'h0, 1'b0);
    checkOutput("div0_remainder", bus.ALUout, 32'd5);

    applyStimulus(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 1'b0);
    bus.out_ready = 1'b0;
    checkOutput("slt_result", bus.ALUout, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("stall_valid", bus.out_valid, 1);
      checkOutput("stall_aluout", bus.ALUout, 32'd1);
      checkOutput("stall_in_ready", bus.in_ready, 0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.ALUOp = ALU_SUBU;
    bus.rdata1 = 32'd10;
    bus.rdata2 = 32'd3;
    bus.BSel = 1'b0;
    bus.in_valid = 1'b1;
    #1;
    checkOutput("release_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checkOutput("release_subu", bus.ALUout, 32'd7);
    checkOutput("release_valid", bus.out_valid, 1);

    applyStimulus(ALU_MULTU, 32'd3, 32'd5, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    checkOutput("flush_in_ready", bus.in_ready, 1);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1;
    end
    checkOutput("flush_no_valid", seen, 0);
    applyStimulus(ALU_MFHI, 32'h0, 32'h0, 1'b0);
    checkOutput("flush_old_hi", bus.ALUout, 32'd5);
    applyStimulus(ALU_SLL, 32'd1, 32'd31, 1'b0);
    checkOutput("sll", bus.ALUout, 32'h8000_0000);

    @(negedge clk);
    bus.ALUOp = ALU_ADDU;
    bus.rdata1 = 32'd1;
    bus.rdata2 = 32'd2;
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    checkOutput("flush_beats_accept", bus.out_valid, 0);

    applyStimulus(ALU_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_aluout", bus.ALUout, 32'h0);
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", bus.in_ready, 1);
    applyStimulus(ALU_MFHI, 32'h0, 32'h0, 1'b0);
    checkOutput("rst_hi_cleared", bus.ALUout, 32'h0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1;
    end
    checkOutput("rst_no_late_result", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
